// File: rtl/ray_generator.sv
// Primary camera ray generator: one ray per pixel in raster order, built incrementally with adds only.
// Optional build macro RAYGEN_ABORT_EN adds an `abort` input that cancels a frame in progress.
module ray_generator #(
  parameter int D_BITS = 32,
  parameter int Q_BITS = 10,
  parameter int X_RES  = 64,
  parameter int Y_RES  = 64
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic signed [D_BITS-1:0] cam_origin [2:0],
  input  logic signed [D_BITS-1:0] cam_corner [2:0],
  input  logic signed [D_BITS-1:0] cam_du     [2:0],
  input  logic signed [D_BITS-1:0] cam_dv     [2:0],
`ifdef RAYGEN_ABORT_EN
  input  logic                     abort,
`endif
  input  logic                     out_full,
  output logic                     out_wr_en,
  output logic signed [D_BITS-1:0] ray_out    [5:0],
  output logic                     busy,
  output logic                     done
);

  localparam int XW = (X_RES > 1) ? $clog2(X_RES) : 1;
  localparam int YW = (Y_RES > 1) ? $clog2(Y_RES) : 1;
  localparam logic [XW-1:0] PX_LAST = XW'(X_RES - 1);
  localparam logic [YW-1:0] PY_LAST = YW'(Y_RES - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_EMIT   = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;

  // Q_BITS only documents the fixed-point scaling; it must still fit inside a word.
  if (Q_BITS >= D_BITS || X_RES < 1 || Y_RES < 1) begin : g_bad_cfg
    $error("ray_generator: illegal parameter set");
  end

  logic [1:0]              state_q, state_d;
  logic [XW-1:0]           px_q, px_d;
  logic [YW-1:0]           py_q, py_d;
  logic signed [D_BITS-1:0] origin_q [2:0], origin_d [2:0];
  logic signed [D_BITS-1:0] du_q     [2:0], du_d     [2:0];
  logic signed [D_BITS-1:0] dv_q     [2:0], dv_d     [2:0];
  logic signed [D_BITS-1:0] row_q    [2:0], row_d    [2:0];
  logic signed [D_BITS-1:0] dir_q    [2:0], dir_d    [2:0];
  logic                    busy_q, done_q;

  assign out_wr_en = (state_q == S_EMIT) && !out_full;
  assign busy      = busy_q;
  assign done      = done_q;

  // Ray word: origin in slots 0..2, direction in slots 3..5.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      ray_out[i]     = origin_q[i];
      ray_out[i + 3] = dir_q[i];
    end
  end

  // Next-state logic: raster walk with per-pixel and per-row direction steps.
  always_comb begin
    state_d  = state_q;
    px_d     = px_q;
    py_d     = py_q;
    origin_d = origin_q;
    du_d     = du_q;
    dv_d     = dv_q;
    row_d    = row_q;
    dir_d    = dir_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          origin_d = cam_origin;
          du_d     = cam_du;
          dv_d     = cam_dv;
          row_d    = cam_corner;
          dir_d    = cam_corner;
          px_d     = '0;
          py_d     = '0;
          state_d  = S_EMIT;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_EMIT: begin
        if (out_wr_en) begin
          if (px_q != PX_LAST) begin
            px_d = px_q + XW'(1);
            for (int i = 0; i < 3; i++) dir_d[i] = dir_q[i] + du_q[i];
          end else if (py_q != PY_LAST) begin
            px_d = '0;
            py_d = py_q + YW'(1);
            for (int i = 0; i < 3; i++) begin
              row_d[i] = row_q[i] + dv_q[i];
              dir_d[i] = row_q[i] + dv_q[i];
            end
          end else begin
            state_d = S_FINISH;
          end
        end else begin
          state_d = S_EMIT;
        end
`ifdef RAYGEN_ABORT_EN
        // Abort overrides the walk; the write of this cycle has already been strobed.
        if (abort) begin
          state_d = S_IDLE;
          px_d    = '0;
          py_d    = '0;
        end else begin
          px_d    = px_d;
        end
`endif
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      px_q     <= '0;
      py_q     <= '0;
      origin_q <= '{default: '0};
      du_q     <= '{default: '0};
      dv_q     <= '{default: '0};
      row_q    <= '{default: '0};
      dir_q    <= '{default: '0};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      px_q     <= px_d;
      py_q     <= py_d;
      origin_q <= origin_d;
      du_q     <= du_d;
      dv_q     <= dv_d;
      row_q    <= row_d;
      dir_q    <= dir_d;
      busy_q   <= (state_d == S_EMIT);
      done_q   <= (state_d == S_FINISH);
    end
  end

endmodule

// File: tb/tb_ray_generator.sv
// Self-checking bench for ray_generator: 4x2 frame instance plus a 1x1 degenerate instance.
module tb_ray_generator;

  localparam int XR = 4;
  localparam int YR = 2;
  localparam int NPIX = XR * YR;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset, start, start1, out_full;
  logic signed [31:0] cam_origin [2:0];
  logic signed [31:0] cam_corner [2:0];
  logic signed [31:0] cam_du     [2:0];
  logic signed [31:0] cam_dv     [2:0];
  logic out_wr_en, busy, done, out_wr_en1, busy1, done1;
  logic signed [31:0] ray_out  [5:0];
  logic signed [31:0] ray_out1 [5:0];
`ifdef RAYGEN_ABORT_EN
  logic abort;
`endif

  ray_generator #(.D_BITS(32), .Q_BITS(10), .X_RES(XR), .Y_RES(YR)) dut (
    .clock(clock), .reset(reset), .start(start),
    .cam_origin(cam_origin), .cam_corner(cam_corner), .cam_du(cam_du), .cam_dv(cam_dv),
`ifdef RAYGEN_ABORT_EN
    .abort(abort),
`endif
    .out_full(out_full), .out_wr_en(out_wr_en), .ray_out(ray_out), .busy(busy), .done(done)
  );

  ray_generator #(.D_BITS(32), .Q_BITS(10), .X_RES(1), .Y_RES(1)) dut1 (
    .clock(clock), .reset(reset), .start(start1),
    .cam_origin(cam_origin), .cam_corner(cam_corner), .cam_du(cam_du), .cam_dv(cam_dv),
`ifdef RAYGEN_ABORT_EN
    .abort(1'b0),
`endif
    .out_full(1'b0), .out_wr_en(out_wr_en1), .ray_out(ray_out1), .busy(busy1), .done(done1)
  );

  typedef struct packed {
    logic [5:0][31:0] c;
    logic [31:0]      stamp;
  } wr_t;

  typedef struct {
    int          idx;
    logic [31:0] dx, dy, dz;
  } vec_t;

  wr_t wr_q[$];
  wr_t wr1_q[$];
  int  done_cnt, done1_cnt, done_stamp, negcnt;
  int  checks, errors;
  logic [31:0] m_org [3], m_cor [3], m_du [3], m_dv [3];

  // Monitor: record every FIFO write and done pulse with its cycle stamp.
  always @(negedge clock) begin
    wr_t w;
    negcnt++;
    if (out_wr_en) begin
      for (int k = 0; k < 6; k++) w.c[k] = ray_out[k];
      w.stamp = negcnt;
      wr_q.push_back(w);
    end
    if (out_wr_en1) begin
      for (int k = 0; k < 6; k++) w.c[k] = ray_out1[k];
      w.stamp = negcnt;
      wr1_q.push_back(w);
    end
    if (done) begin
      done_cnt++;
      done_stamp = negcnt;
    end
    if (done1) done1_cnt++;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic set_cam(input logic [31:0] ox, oy, oz, cx, cy, cz, ux, uy, uz, vx, vy, vz);
    m_org[0] = ox; m_org[1] = oy; m_org[2] = oz;
    m_cor[0] = cx; m_cor[1] = cy; m_cor[2] = cz;
    m_du[0]  = ux; m_du[1]  = uy; m_du[2]  = uz;
    m_dv[0]  = vx; m_dv[1]  = vy; m_dv[2]  = vz;
    for (int a = 0; a < 3; a++) begin
      cam_origin[a] = m_org[a];
      cam_corner[a] = m_cor[a];
      cam_du[a]     = m_du[a];
      cam_dv[a]     = m_dv[a];
    end
  endtask

  // Reference direction: corner + x*du + y*dv, modulo 2^32.
  function automatic logic [31:0] mdl(input int a, input int p);
    logic [31:0] xs, ys;
    xs = 32'(p % XR);
    ys = 32'(p / XR);
    return m_cor[a] + xs * m_du[a] + ys * m_dv[a];
  endfunction

  task automatic check_frame(input string tag);
    chk({tag, "_count"}, 32'(wr_q.size()), 32'(NPIX));
    for (int i = 0; i < NPIX && i < wr_q.size(); i++) begin
      for (int a = 0; a < 3; a++) begin
        chk($sformatf("%s_org%0d_%0d", tag, i, a), wr_q[i].c[a], m_org[a]);
        chk($sformatf("%s_dir%0d_%0d", tag, i, a), wr_q[i].c[3 + a], mdl(a, i));
      end
    end
  endtask

  task automatic wait_done(input int max_cyc);
    int n = 0;
    while (done_cnt == 0 && n < max_cyc) begin
      tick();
      n++;
    end
    if (done_cnt == 0) chk("done_timeout", 32'd0, 32'd1);
    repeat (3) tick();
    chk("done_count", 32'(done_cnt), 32'd1);
  endtask

  task automatic run_frame(input bit rnd_full, output int s0);
    int n = 0;
    wr_q.delete();
    done_cnt = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    s0 = negcnt;
    out_full = rnd_full ? ($urandom_range(0, 2) == 0) : 1'b0;
    @(negedge clock);
    chk("busy_rise", 32'(busy), 32'd1);
    while (done_cnt == 0 && n < 300) begin
      tick();
      out_full = rnd_full ? ($urandom_range(0, 2) == 0) : 1'b0;
      n++;
    end
    out_full = 1'b0;
    if (done_cnt == 0) chk("done_timeout", 32'd0, 32'd1);
    repeat (3) tick();
    chk("done_count", 32'(done_cnt), 32'd1);
  endtask

  vec_t vecs [4];
  int   s0;

  initial begin
    checks = 0; errors = 0; negcnt = 0; done_cnt = 0; done1_cnt = 0; done_stamp = 0;
    reset = 1'b1; start = 1'b0; start1 = 1'b0; out_full = 1'b0;
`ifdef RAYGEN_ABORT_EN
    abort = 1'b0;
`endif
    set_cam(32'd0, 32'd0, 32'd0, -32'sd2048, 32'sd1024, -32'sd1024,
            32'sd1024, 32'd0, 32'd0, 32'd0, -32'sd512, 32'd0);
    vecs[0] = '{0, -32'sd2048, 32'sd1024, -32'sd1024};
    vecs[1] = '{1, -32'sd1024, 32'sd1024, -32'sd1024};
    vecs[2] = '{4, -32'sd2048, 32'sd512,  -32'sd1024};
    vecs[3] = '{7,  32'sd1024, 32'sd512,  -32'sd1024};
    repeat (3) tick();
    reset = 1'b0;

    // Reset state
    @(negedge clock);
    chk("rst_wr_en", 32'(out_wr_en), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_done",  32'(done), 32'd0);
    for (int k = 0; k < 6; k++) chk($sformatf("rst_ray%0d", k), ray_out[k], 32'd0);
    tick();

    // 1: basic frame, timing and fixed vectors
    run_frame(1'b0, s0);
    check_frame("f1");
    if (wr_q.size() == NPIX) begin
      chk("f1_first_lat", wr_q[0].stamp, 32'(s0 + 1));
      chk("f1_last_lat",  wr_q[NPIX-1].stamp, 32'(s0 + NPIX));
      for (int v = 0; v < 4; v++) begin
        chk($sformatf("f1_vec%0d_x", vecs[v].idx), wr_q[vecs[v].idx].c[3], vecs[v].dx);
        chk($sformatf("f1_vec%0d_y", vecs[v].idx), wr_q[vecs[v].idx].c[4], vecs[v].dy);
        chk($sformatf("f1_vec%0d_z", vecs[v].idx), wr_q[vecs[v].idx].c[5], vecs[v].dz);
      end
    end
    chk("f1_done_lat", 32'(done_stamp), 32'(s0 + NPIX + 1));

    // 2: stall for 5 cycles after the third write
    wr_q.delete();
    done_cnt = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    out_full = 1'b1;
    for (int s = 0; s < 5; s++) begin
      @(negedge clock);
      chk($sformatf("stall%0d_wr_en", s), 32'(out_wr_en), 32'd0);
      for (int a = 0; a < 3; a++)
        chk($sformatf("stall%0d_dir%0d", s, a), ray_out[3 + a], mdl(a, 3));
      tick();
    end
    out_full = 1'b0;
    chk("stall_pre_count", 32'(wr_q.size()), 32'd3);
    wait_done(50);
    check_frame("f2");
    if (wr_q.size() > 3) begin
      chk("f2_p3_x", wr_q[3].c[3], 32'sd1024);
      chk("f2_p3_y", wr_q[3].c[4], 32'sd1024);
      chk("f2_p3_z", wr_q[3].c[5], -32'sd1024);
    end

    // 3: two's-complement wrap on x
    set_cam(32'd5, 32'd6, 32'd7, 32'h7FFF_FC00, 32'sd1024, -32'sd1024,
            32'sd1024, 32'd0, 32'd0, 32'd0, -32'sd512, 32'd0);
    run_frame(1'b0, s0);
    check_frame("f3");
    if (wr_q.size() > 1) chk("f3_wrap_x", wr_q[1].c[3], 32'h8000_0000);

    // 4: second start and corner change mid-frame are ignored
    set_cam(32'd1, 32'd2, 32'd3, -32'sd2048, 32'sd1024, -32'sd1024,
            32'sd1024, 32'd0, 32'd0, 32'd0, -32'sd512, 32'd0);
    wr_q.delete();
    done_cnt = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1;
    cam_corner[0] = 32'sd99999;
    cam_corner[1] = -32'sd7;
    tick();
    start = 1'b0;
    cam_corner[2] = 32'sd12345;
    wait_done(50);
    check_frame("f4");
    set_cam(32'd1, 32'd2, 32'd3, -32'sd2048, 32'sd1024, -32'sd1024,
            32'sd1024, 32'd0, 32'd0, 32'd0, -32'sd512, 32'd0);

    // 5: reset during the fifth write cycle
    wr_q.delete();
    done_cnt = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (6) tick();
    @(negedge clock);
    chk("rst5_writes", 32'(wr_q.size()), 32'd5);
    chk("rst5_done",   32'(done_cnt), 32'd0);
    chk("rst5_busy",   32'(busy), 32'd0);
    chk("rst5_wr_en",  32'(out_wr_en), 32'd0);
    chk("rst5_dir0",   ray_out[3], 32'd0);
    tick();
    run_frame(1'b0, s0);
    check_frame("f5");

    // 6: 1x1 frame
    wr1_q.delete();
    done1_cnt = 0;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    repeat (5) tick();
    chk("one_count", 32'(wr1_q.size()), 32'd1);
    chk("one_done",  32'(done1_cnt), 32'd1);
    if (wr1_q.size() > 0)
      for (int a = 0; a < 3; a++) chk($sformatf("one_dir%0d", a), wr1_q[0].c[3 + a], m_cor[a]);

`ifdef RAYGEN_ABORT_EN
    wr_q.delete();
    done_cnt = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    repeat (5) tick();
    @(negedge clock);
    chk("abort_writes", 32'(wr_q.size()), 32'd2);
    chk("abort_done",   32'(done_cnt), 32'd0);
    chk("abort_busy",   32'(busy), 32'd0);
    tick();
`endif

    // Randomized frames with random back-pressure
    for (int r = 0; r < 5; r++) begin
      set_cam($urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
              $urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
      run_frame(1'b1, s0);
      check_frame($sformatf("rnd%0d", r));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ray_generator.md
Name: ray_generator

Overview:
Produces one primary camera ray per pixel in raster order and writes each ray into the ray input FIFO that the streamer drains. Directions are built incrementally from a latched camera corner vector and per-pixel and per-row step vectors using adds only, with no multipliers. A frame is started by a single `start` pulse and finishes with a one-cycle `done` pulse.

Parameters:
- D_BITS, 32: word width of each ray component, signed fixed point.
- Q_BITS, 10: fractional bits; 1.0 = 1024. Documentation only; no arithmetic depends on it.
- X_RES, 64: pixels per row, must be ≥1.
- Y_RES, 64: rows per frame, must be ≥1.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  begin a frame; sampled only in IDLE
- cam_origin  in  signed D_BITS [2:0]  ray origin x,y,z
- cam_corner  in  signed D_BITS [2:0]  direction of pixel (0,0)
- cam_du  in  signed D_BITS [2:0]  direction step per +1 x
- cam_dv  in  signed D_BITS [2:0]  direction step per +1 y
- out_full  in  1  full flag of the ray FIFO
- out_wr_en  out  1  write strobe to the ray FIFO
- ray_out  out  signed D_BITS [5:0]  [0..2] = origin x,y,z; [3..5] = direction x,y,z
- busy  out  1  high from the cycle after `start` is accepted until `done`
- done  out  1  one-cycle pulse after the last ray is written

Behaviour:
- States: IDLE, EMIT, FINISH.
- Reset: state = IDLE. `out_wr_en`, `busy` and `done` are 0. `px`, `py` are 0. All ray and row registers are 0, so `ray_out` = 0.
- IDLE:
  - On `start`=1, latch origin, du and dv.
  - Load row_dir and dir with `cam_corner`; set px = py = 0.
  - Go to EMIT. Output `busy` rises on the next cycle.
- EMIT:
  - `out_wr_en` = (state==EMIT) && !`out_full`, combinational.
  - `ray_out` is driven from registers and is valid whenever state==EMIT.
  - On a write edge (`out_wr_en`=1):
    - If px < X_RES-1: px++, dir += du.
    - Else if py < Y_RES-1: px = 0, py++, row_dir += dv, dir = row_dir + dv.
    - Else go to FINISH.
  - When `out_full`=1: no write; px, py, dir and `ray_out` hold unchanged for any number of cycles.
  - Throughput is 1 ray/cycle when not full. First write is possible 1 cycle after `start`.
- FINISH:
  - `done`=1 and `busy`=0 for exactly one cycle, then go to IDLE.
  - `out_wr_en`=0.
- Exactly X_RES*Y_RES writes per frame.
- `start` is ignored in EMIT and FINISH. Changes on the `cam_*` inputs after the latch have no effect.
- Arithmetic: D_BITS two's-complement add with silent wrap-around; no saturation and no overflow flag.
- Counter widths: $clog2 of resolution, minimum 1 bit. X_RES=1 and/or Y_RES=1 are legal and must still yield exactly X_RES*Y_RES writes.
- Reset asserted mid-frame: next edge returns to IDLE with reset values. No `done` pulse; no further writes.

Optional Feature:
Macro RAYGEN_ABORT_EN.
- Defined: adds input port `abort` (1 bit).
  - `abort`=1 in EMIT, on its own or together with a write edge, goes to IDLE at the next edge. That cycle's write, if any, still occurs.
  - Counters clear; no `done` pulse; `busy` falls.
  - `abort` is ignored in IDLE and FINISH.
- Undefined: no `abort` port; the frame always runs to completion.

Test Plan:
1. Frame values: X_RES=4, Y_RES=2, origin=(0,0,0), corner=(-2048,1024,-1024), du=(1024,0,0), dv=(0,-512,0), `out_full`=0. Pulse `start`. Required response:
   - 8 consecutive writes starting 1 cycle later.
   - Pixel (1,0) direction = (-1024,1024,-1024).
   - Pixel (0,1) direction = (-2048,512,-1024).
   - Pixel (3,1) direction = (1024,512,-1024).
   - `done` pulses once, 1 cycle after the 8th write.
2. Same setup; hold `out_full`=1 for 5 cycles after the 3rd write:
   - `out_wr_en`=0 and `ray_out` stable throughout the stall.
   - Next write is pixel (3,0) with direction (1024,1024,-1024).
   - Total writes still 8.
3. Wrap: corner x=32'h7FFF_FC00, du x=1024 -> pixel (1,0) direction x = 32'h8000_0000.
4. Pulse `start` again mid-frame; change `cam_corner` after the latch -> no restart, output unaffected, exactly one `done`.
5. Assert `reset` after the 5th write -> no further writes, state IDLE, `busy`=0, no `done`. A fresh `start` produces a full 8-ray frame from pixel (0,0).
6. Degenerate frame X_RES=1, Y_RES=1 -> exactly 1 write with direction = corner, then `done`. With RAYGEN_ABORT_EN defined: `abort` after the 2nd write of scenario 1 -> 2 writes total, no `done`.
